// File: rtl/pam_search_pkg.sv
// Shared types and register map for the PAM search sequencer.
package pam_search_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWb,
    StGo,
    StPollAr,
    StPollR,
    StGap,
    StFin
  } state_e;

  // Completion codes reported on err alongside done.
  localparam logic [1:0] ErrOk      = 2'd0;
  localparam logic [1:0] ErrBresp   = 2'd1;
  localparam logic [1:0] ErrRresp   = 2'd2;
  localparam logic [1:0] ErrTimeout = 2'd3;

  // Slave register byte offsets.
  localparam logic [7:0] REG_PATTERN = 8'h00;
  localparam logic [7:0] REG_BASE    = 8'h04;
  localparam logic [7:0] REG_LEN     = 8'h08;
  localparam logic [7:0] REG_CTRL    = 8'h0C;

  // CTRL register bit positions.
  localparam int unsigned CtrlGoBit   = 0;
  localparam int unsigned CtrlDoneBit = 1;

  // Offset of the n-th register in the configuration write sequence.
  function automatic logic [7:0] reg_offset(input logic [1:0] idx);
    logic [7:0] off;
    case (idx)
      2'd0:    off = REG_PATTERN;
      2'd1:    off = REG_BASE;
      2'd2:    off = REG_LEN;
      default: off = REG_CTRL;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/pam_axil_wr_chan.sv
// Single AXI4-Lite write: launches AW and W together, retires each on its own
// handshake, and exposes the B handshake to the controlling FSM.
module pam_axil_wr_chan #(
  parameter int unsigned AddrWidth = 4,
  parameter int unsigned DataWidth = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic [AddrWidth-1:0]   addr,
  input  logic [DataWidth-1:0]   data,
  input  logic                   b_en,
  output logic                   issued,
  output logic                   hs_done,
  output logic                   b_fire,
  output logic                   b_err,
  output logic [AddrWidth-1:0]   awaddr,
  output logic [2:0]             awprot,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [DataWidth-1:0]   wdata,
  output logic [DataWidth/8-1:0] wstrb,
  output logic                   wvalid,
  input  logic                   wready,
  input  logic [1:0]             bresp,
  input  logic                   bvalid,
  output logic                   bready
);

  logic                 issued_q;
  logic                 awvalid_q;
  logic                 wvalid_q;
  logic                 aw_seen_q;
  logic                 w_seen_q;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] data_q;
  logic                 aw_fire;
  logic                 w_fire;

  assign aw_fire = awvalid_q & awready;
  assign w_fire  = wvalid_q & wready;
  // Both address and data accepted, in either order or together.
  assign hs_done = issued_q & (aw_seen_q | aw_fire) & (w_seen_q | w_fire);

  // Launch on req; each VALID drops the cycle after its own handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_seen_q <= 1'b0;
      w_seen_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else if (req) begin
      issued_q  <= 1'b1;
      awvalid_q <= 1'b1;
      wvalid_q  <= 1'b1;
      aw_seen_q <= 1'b0;
      w_seen_q  <= 1'b0;
      addr_q    <= addr;
      data_q    <= data;
    end else begin
      if (aw_fire) begin
        awvalid_q <= 1'b0;
        aw_seen_q <= 1'b1;
      end
      if (w_fire) begin
        wvalid_q <= 1'b0;
        w_seen_q <= 1'b1;
      end
      if (hs_done) begin
        issued_q <= 1'b0;
      end
    end
  end

  assign issued  = issued_q;
  assign awaddr  = addr_q;
  assign awprot  = 3'b000;
  assign awvalid = awvalid_q;
  assign wdata   = data_q;
  assign wstrb   = '1;
  assign wvalid  = wvalid_q;
  assign bready  = b_en;
  assign b_fire  = bvalid & b_en;
  assign b_err   = b_fire & (bresp != 2'b00);

endmodule

// File: rtl/pam_search_sequencer.sv
// AXI4-Lite master that programs a PAM search engine (pattern, base, len),
// kicks it via CTRL.GO and polls CTRL.DONE until completion or timeout.
module pam_search_sequencer
  import pam_search_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 4,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned POLL_GAP           = 8,
  parameter int unsigned MAX_POLLS          = 1024
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            start,
  input  logic [31:0]                     cfg_pattern,
  input  logic [31:0]                     cfg_base,
  input  logic [31:0]                     cfg_len,
  output logic                            busy,
  output logic                            done,
  output logic [1:0]                      err,
  output logic [31:0]                     result,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam logic [15:0] MaxPollsW = 16'(MAX_POLLS);
  localparam logic [7:0]  GapLast   = 8'(POLL_GAP - 1);

  state_e      state_q, state_d;
  logic [1:0]  wr_idx_q, wr_idx_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic        arvalid_q, arvalid_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] result_q, result_d;
  logic [31:0] pattern_q, base_q, len_q;
  logic        capture;

  logic                          wr_req;
  logic                          wr_issued;
  logic                          wr_hs_done;
  logic                          wr_b_fire;
  logic                          wr_b_err;
  logic [C_M_AXI_DATA_WIDTH-1:0] wr_data;

  // Data for the current write slot; the last slot sets CTRL.GO.
  always_comb begin
    wr_data = '0;
    case (wr_idx_q)
      2'd0:    wr_data = pattern_q;
      2'd1:    wr_data = base_q;
      2'd2:    wr_data = len_q;
      default: wr_data = 32'h1 << CtrlGoBit;
    endcase
  end

  pam_axil_wr_chan #(
    .AddrWidth(C_M_AXI_ADDR_WIDTH),
    .DataWidth(C_M_AXI_DATA_WIDTH)
  ) u_wr_chan (
    .clk    (ACLK),
    .rst_n  (ARESETN),
    .req    (wr_req),
    .addr   (C_M_AXI_ADDR_WIDTH'(reg_offset(wr_idx_q))),
    .data   (wr_data),
    .b_en   (state_q == StWb),
    .issued (wr_issued),
    .hs_done(wr_hs_done),
    .b_fire (wr_b_fire),
    .b_err  (wr_b_err),
    .awaddr (M_AXI_AWADDR),
    .awprot (M_AXI_AWPROT),
    .awvalid(M_AXI_AWVALID),
    .awready(M_AXI_AWREADY),
    .wdata  (M_AXI_WDATA),
    .wstrb  (M_AXI_WSTRB),
    .wvalid (M_AXI_WVALID),
    .wready (M_AXI_WREADY),
    .bresp  (M_AXI_BRESP),
    .bvalid (M_AXI_BVALID),
    .bready (M_AXI_BREADY)
  );

  // Sequencer next-state: config writes, GO write, then poll/gap loop.
  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    poll_cnt_d = poll_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    arvalid_d  = arvalid_q;
    err_d      = err_q;
    result_d   = result_q;
    wr_req     = 1'b0;
    capture    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          capture    = 1'b1;
          state_d    = StWr;
          wr_idx_d   = 2'd0;
          poll_cnt_d = '0;
          err_d      = ErrOk;
          result_d   = '0;
        end
      end
      StWr, StGo: begin
        if (!wr_issued) begin
          wr_req = 1'b1;
        end else if (wr_hs_done) begin
          state_d = StWb;
        end
      end
      StWb: begin
        if (wr_b_fire) begin
          if (wr_b_err) begin
            err_d   = ErrBresp;
            state_d = StFin;
          end else if (wr_idx_q == 2'd3) begin
            poll_cnt_d = '0;
            state_d    = StPollAr;
          end else begin
            wr_idx_d = wr_idx_q + 2'd1;
            state_d  = (wr_idx_q == 2'd2) ? StGo : StWr;
          end
        end
      end
      StPollAr: begin
        // First cycle raises ARVALID; it then holds until ARREADY.
        if (!arvalid_q) begin
          arvalid_d = 1'b1;
        end else if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = StPollR;
        end
      end
      StPollR: begin
        if (M_AXI_RVALID) begin
          result_d = M_AXI_RDATA[31:0];
          if (M_AXI_RRESP != 2'b00) begin
            err_d   = ErrRresp;
            state_d = StFin;
          end else if (M_AXI_RDATA[CtrlDoneBit]) begin
            err_d   = ErrOk;
            state_d = StFin;
          end else begin
            poll_cnt_d = poll_cnt_q + 16'd1;
            if (poll_cnt_d == MaxPollsW) begin
              err_d   = ErrTimeout;
              state_d = StFin;
            end else begin
              gap_cnt_d = '0;
              state_d   = StGap;
            end
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d = StPollAr;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= StIdle;
      wr_idx_q   <= '0;
      poll_cnt_q <= '0;
      gap_cnt_q  <= '0;
      arvalid_q  <= 1'b0;
      err_q      <= ErrOk;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      poll_cnt_q <= poll_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      arvalid_q  <= arvalid_d;
      err_q      <= err_d;
      result_q   <= result_d;
    end
  end

  // Configuration snapshot taken only when a start is accepted.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pattern_q <= '0;
      base_q    <= '0;
      len_q     <= '0;
    end else if (capture) begin
      pattern_q <= cfg_pattern;
      base_q    <= cfg_base;
      len_q     <= cfg_len;
    end
  end

  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StFin);
  assign err           = err_q;
  assign result        = result_q;
  assign M_AXI_ARADDR  = C_M_AXI_ADDR_WIDTH'(REG_CTRL);
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = (state_q == StPollR);

endmodule

// File: tb/tb_pam_search_sequencer.sv
// Bench for pam_search_sequencer: behavioural AXI4-Lite slave plus a
// transaction-level model of the expected write/poll sequence.
module tb_pam_search_sequencer;

  localparam int unsigned AW       = 4;
  localparam int unsigned PollGap  = 8;
  localparam int unsigned MaxPolls = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [31:0] cfg_pattern = '0;
  logic [31:0] cfg_base = '0;
  logic [31:0] cfg_len = '0;
  logic busy, done;
  logic [1:0] err;
  logic [31:0] result;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Slave configuration (set per scenario).
  int aw_dly = 0;
  int w_dly = 0;
  int berr_idx = 4;
  int done_poll = 1;
  int ar_base = 0;
  logic [31:0] noise = '0;

  // Slave state and transaction logs.
  int aw_cnt = 0;
  int w_cnt = 0;
  logic aw_got = 1'b0;
  logic w_got = 1'b0;
  logic [AW-1:0] aw_l = '0;
  logic [31:0] w_l = '0;
  logic bvalid_r = 1'b0;
  logic [1:0] bresp_r = '0;
  logic rvalid_r = 1'b0;
  logic [31:0] rdata_r = '0;
  int n_aw = 0;
  int n_w = 0;
  int n_wr = 0;
  int n_ar = 0;
  logic [AW-1:0] log_addr [256];
  logic [31:0] log_data [256];
  int ar_cyc [256];
  logic [AW-1:0] cur_addr;
  logic [31:0] cur_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pam_search_sequencer #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(32),
    .POLL_GAP(PollGap),
    .MAX_POLLS(MaxPolls)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n), .start(start),
    .cfg_pattern(cfg_pattern), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .busy(busy), .done(done), .err(err), .result(result),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  // Status word the slave returns on poll p (1-based); DONE set only on poll dp.
  function automatic logic [31:0] status_word(input int p, input int dp, input logic [31:0] nz);
    logic [31:0] w;
    w = nz * 32'(p);
    w[1] = (p == dp);
    return w;
  endfunction

  assign awready  = (aw_cnt >= aw_dly);
  assign wready   = (w_cnt >= w_dly);
  assign arready  = 1'b1;
  assign bvalid   = bvalid_r;
  assign bresp    = bresp_r;
  assign rvalid   = rvalid_r;
  assign rdata    = rdata_r;
  assign rresp    = 2'b00;
  assign cur_addr = aw_got ? aw_l : awaddr;
  assign cur_data = w_got ? w_l : wdata;

  // Behavioural AXI4-Lite slave: optional AW/W ready delays, B one cycle after
  // both halves of a write, R one cycle after AR.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      bvalid_r <= 1'b0; bresp_r <= 2'b00; rvalid_r <= 1'b0; rdata_r <= '0;
    end else begin
      if (awvalid && awready) begin
        aw_got <= 1'b1; aw_l <= awaddr; aw_cnt <= 0; n_aw <= n_aw + 1;
      end else if (awvalid) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (wvalid && wready) begin
        w_got <= 1'b1; w_l <= wdata; w_cnt <= 0; n_w <= n_w + 1;
      end else if (wvalid) begin
        w_cnt <= w_cnt + 1;
      end
      if (bvalid_r && bready) bvalid_r <= 1'b0;
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
        log_addr[n_wr & 255] <= cur_addr;
        log_data[n_wr & 255] <= cur_data;
        n_wr <= n_wr + 1;
        bvalid_r <= 1'b1;
        bresp_r <= (berr_idx < 4 && cur_addr == AW'(4 * berr_idx)) ? 2'b10 : 2'b00;
        aw_got <= 1'b0;
        w_got <= 1'b0;
      end
      if (rvalid_r && rready) rvalid_r <= 1'b0;
      if (arvalid && arready) begin
        ar_cyc[n_ar & 255] <= cyc;
        n_ar <= n_ar + 1;
        rvalid_r <= 1'b1;
        rdata_r <= status_word(n_ar - ar_base + 1, done_poll, noise);
      end
    end
  end

  // One full sequence against the model. bidx<4 injects SLVERR on that write,
  // dpoll is the poll that reports DONE (0 = never), poke pulses start while busy.
  task automatic run_seq(input string name, input logic [31:0] pat, input logic [31:0] base,
                         input logic [31:0] len, input int bidx, input int dpoll,
                         input int awd, input int wd, input bit poke, input logic [31:0] nz);
    int s, dcyc, nwr0, naw0, nw0, nar0, npolls, exp_wr, exp_lat, viol;
    bit got;
    logic [1:0] exp_err;
    logic [31:0] exp_res;
    logic [31:0] exp_data [4];
    logic pv_aw, pv_awr, pv_w, pv_wr, pv_ar, pv_arr;
    logic [AW-1:0] pv_awaddr;
    logic [31:0] pv_wdata;

    exp_data[0] = pat; exp_data[1] = base; exp_data[2] = len; exp_data[3] = 32'h1;
    exp_res = '0;
    if (bidx < 4) begin
      exp_wr = bidx + 1; npolls = 0; exp_err = 2'd1; exp_lat = 3 * (bidx + 1) + 1;
    end else begin
      exp_wr = 4;
      if (dpoll >= 1 && dpoll <= int'(MaxPolls)) begin
        npolls = dpoll; exp_err = 2'd0;
      end else begin
        npolls = MaxPolls; exp_err = 2'd3;
      end
      exp_res = status_word(npolls, dpoll, nz);
      exp_lat = 16 + (npolls - 1) * (PollGap + 3);
    end

    aw_dly = awd; w_dly = wd; berr_idx = bidx; done_poll = dpoll; noise = nz;
    nwr0 = n_wr; naw0 = n_aw; nw0 = n_w; nar0 = n_ar; ar_base = n_ar;

    @(negedge clk);
    cfg_pattern = pat; cfg_base = base; cfg_len = len; start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    cfg_pattern = $urandom; cfg_base = $urandom; cfg_len = $urandom;

    got = 1'b0; dcyc = 0; viol = 0;
    pv_aw = 0; pv_awr = 0; pv_w = 0; pv_wr = 0; pv_ar = 0; pv_arr = 0;
    pv_awaddr = '0; pv_wdata = '0;
    for (int i = 0; i < 3000 && !got; i++) begin
      if (done) begin
        got = 1'b1;
        dcyc = cyc;
      end else begin
        if (pv_aw && !pv_awr && (!awvalid || awaddr !== pv_awaddr)) viol++;
        if (pv_w && !pv_wr && (!wvalid || wdata !== pv_wdata)) viol++;
        if (pv_ar && !pv_arr && !arvalid) viol++;
        if (bready && (awvalid || wvalid || arvalid)) viol++;
        pv_aw = awvalid; pv_awr = awready; pv_awaddr = awaddr;
        pv_w = wvalid; pv_wr = wready; pv_wdata = wdata;
        pv_ar = arvalid; pv_arr = arready;
        start = (poke && (i == 4 || i == 20));
        if (poke && start) begin
          cfg_pattern = ~pat; cfg_base = ~base; cfg_len = ~len;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;

    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s done_timeout: got no done, want done within 3000 cycles", name);
    end else begin
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL %s busy_at_done: got %b want 1", name, busy);
      end
      checks++;
      if (err !== exp_err) begin
        errors++; $display("FAIL %s err: got %0d want %0d", name, err, exp_err);
      end
      if (bidx >= 4) begin
        checks++;
        if (result !== exp_res) begin
          errors++; $display("FAIL %s result: got %h want %h", name, result, exp_res);
        end
      end
      if (awd == 0 && wd == 0) begin
        checks++;
        if (dcyc - s != exp_lat) begin
          errors++; $display("FAIL %s latency: got %0d want %0d", name, dcyc - s, exp_lat);
        end
      end
      checks++;
      if (n_wr - nwr0 != exp_wr || n_aw - naw0 != exp_wr || n_w - nw0 != exp_wr) begin
        errors++;
        $display("FAIL %s write_count: got wr=%0d aw=%0d w=%0d want %0d", name,
                 n_wr - nwr0, n_aw - naw0, n_w - nw0, exp_wr);
      end
      for (int k = 0; k < exp_wr && k < n_wr - nwr0; k++) begin
        checks++;
        if (log_addr[(nwr0 + k) & 255] !== AW'(4 * k) ||
            log_data[(nwr0 + k) & 255] !== exp_data[k]) begin
          errors++;
          $display("FAIL %s write%0d: got %h/%h want %h/%h", name, k,
                   log_addr[(nwr0 + k) & 255], log_data[(nwr0 + k) & 255], AW'(4 * k),
                   exp_data[k]);
        end
      end
      checks++;
      if (n_ar - nar0 != npolls) begin
        errors++; $display("FAIL %s poll_count: got %0d want %0d", name, n_ar - nar0, npolls);
      end
      for (int k = 1; k < npolls && k < n_ar - nar0; k++) begin
        checks++;
        if (ar_cyc[(nar0 + k) & 255] - ar_cyc[(nar0 + k - 1) & 255] < int'(PollGap) + 1) begin
          errors++;
          $display("FAIL %s poll_spacing%0d: got %0d want >= %0d", name, k,
                   ar_cyc[(nar0 + k) & 255] - ar_cyc[(nar0 + k - 1) & 255], PollGap + 1);
        end
      end
      checks++;
      if (viol != 0) begin
        errors++; $display("FAIL %s protocol: got %0d violations want 0", name, viol);
      end
      // Start coincident with done must be ignored.
      start = poke;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s after_done: got busy=%b done=%b want 0/0", name, busy, done);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({busy, done, err, result} !== 36'd0) begin
      errors++;
      $display("FAIL reset_status: got busy=%b done=%b err=%0d result=%h want zeros",
               busy, done, err, result);
    end
    checks++;
    if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_handshake: got %b want 00000",
               {awvalid, wvalid, bready, arvalid, rready});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_release_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_basic();
    run_seq("basic", 32'hA5A5A5A5, 32'h100, 32'h40, 4, 1, 0, 0, 1'b0, 32'h0);
    checks++;
    if (result !== 32'h00000002) begin
      errors++; $display("FAIL basic_result_word: got %h want 00000002", result);
    end
  endtask

  task automatic test_w_before_aw();
    run_seq("w_before_aw", $urandom, $urandom, $urandom, 4, 2, 3, 0, 1'b0, $urandom);
  endtask

  task automatic test_bresp_err();
    run_seq("bresp_err", $urandom, $urandom, $urandom, 1, 1, 0, 0, 1'b0, $urandom);
  endtask

  task automatic test_timeout();
    run_seq("timeout", $urandom, $urandom, $urandom, 4, 0, 0, 0, 1'b0, $urandom);
  endtask

  task automatic test_start_while_busy();
    run_seq("start_busy", $urandom, $urandom, $urandom, 4, 2, 0, 0, 1'b1, $urandom);
  endtask

  task automatic test_reset_mid();
    bit seen;
    aw_dly = 0; w_dly = 0; berr_idx = 4; done_poll = 1; ar_base = n_ar;
    @(negedge clk);
    cfg_pattern = $urandom; cfg_base = $urandom; cfg_len = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (wvalid && awaddr == AW'(4)) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL reset_mid_wvalid: got no WVALID on 0x4 want WVALID within 50");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, busy, done} !== 7'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b want 0000000",
               {awvalid, wvalid, arvalid, bready, rready, busy, done});
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || err !== 2'd0) begin
      errors++; $display("FAIL reset_mid_idle: got busy=%b err=%0d want 0/0", busy, err);
    end
    run_seq("after_reset", $urandom, $urandom, $urandom, 4, 1, 0, 0, 1'b0, $urandom);
  endtask

  task automatic test_random();
    int bidx;
    for (int n = 0; n < 8; n++) begin
      bidx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 4;
      run_seq($sformatf("random%0d", n), $urandom, $urandom, $urandom, bidx,
              int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_w_before_aw();
    test_bresp_err();
    test_timeout();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pam_search_sequencer.md
PAM_SEARCH_SEQUENCER -- requirements
Module: pam_search_sequencer

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 4, AXI4-Lite byte-address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-003 SHALL have parameter POLL_GAP, default 8, idle cycles between status polls (1..255).
REQ-004 SHALL have parameter MAX_POLLS, default 1024, poll reads before timeout (1..65535).
REQ-005 ACLK  in  1  single clock; all logic rising-edge.
REQ-006 ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-007 start  in  1  one-cycle request; sampled only in IDLE.
REQ-008 cfg_pattern, cfg_base, cfg_len  in  32 each  values for slave regs 0x0, 0x4, 0x8; captured on accepted start.
REQ-009 busy  out  1  high from accepted start until done pulse inclusive.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 err  out  2  valid with done: 0 ok, 1 BRESP error, 2 RRESP error, 3 poll timeout.
REQ-012 result  out  32  last status word read from 0xC; valid with done, held until next start.
REQ-013 M_AXI_AW* (ADDR, PROT=0, VALID, READY), M_AXI_W* (DATA, STRB=4'hF, VALID, READY), M_AXI_B* (RESP, VALID, READY) SHALL form a standard AXI4-Lite write master.
REQ-014 M_AXI_AR* (ADDR, PROT=0, VALID, READY), M_AXI_R* (DATA, RESP, VALID, READY) SHALL form a standard AXI4-Lite read master.

Function
REQ-015 States SHALL be IDLE, WR (AW/W outstanding), WB (await B), GO (write 0x1 to 0xC), POLL_AR, POLL_R, GAP, FIN.
REQ-016 IDLE+start SHALL capture cfg_* and enter WR with target offset 0x0 the next cycle; start outside IDLE SHALL be ignored.
REQ-017 In WR, AWVALID and WVALID SHALL assert together; each deasserts the cycle after its own handshake; state leaves WR only when both handshakes completed (any order, same cycle allowed).
REQ-018 VALID SHALL never drop before READY; ADDR/DATA stable while VALID high.
REQ-019 BREADY SHALL be high only in WB; on BVALID with BRESP!=0 go to FIN with err=1; else advance 0x0->0x4->0x8->GO.
REQ-020 GO SHALL run the WR/WB sequence with address 0xC, data 0x00000001; on good B enter POLL_AR with poll count 0.
REQ-021 POLL_AR SHALL drive ARVALID, ARADDR=0xC until ARREADY; POLL_R drives RREADY=1 until RVALID.
REQ-022 On R: RRESP!=0 -> FIN err=2; RDATA[1]=1 -> latch result, FIN err=0; else increment poll count; count==MAX_POLLS -> FIN err=3 (result=last RDATA), otherwise GAP.
REQ-023 GAP SHALL wait exactly POLL_GAP cycles, then POLL_AR.
REQ-024 FIN SHALL pulse done for one cycle, then IDLE; a start coincident with done is ignored.
REQ-025 At most one read and one write transaction SHALL be outstanding; reads and writes never overlap.
REQ-026 Minimum latency start->done with zero-wait slave, done on first poll: 4 writes x 3 cycles + 3 poll cycles + 1 = 16 cycles.

Reset
REQ-027 ARESETN low SHALL asynchronously force IDLE, all VALID/READY outputs 0, busy=0, done=0, err=0, result=0, counters 0.
REQ-028 Reset mid-transaction SHALL abandon it with no recovery; first cycle after deassert is IDLE.

Structure
REQ-029 Package pam_search_pkg SHALL hold the state enum, err codes, and register offsets (REG_PATTERN 0x0, REG_BASE 0x4, REG_LEN 0x8, REG_CTRL 0xC) and CTRL bit positions (GO=0, DONE=1).
REQ-030 Sub-module pam_axil_wr_chan SHALL implement the AW/W/B single-write handshake (REQ-017..019); read path stays inline.

Verification
REQ-031 Zero-wait slave, pattern 0xA5A5A5A5, base 0x100, len 0x40, status done on poll 1 -> writes in order 0x0/0x4/0x8/0xC, done at cycle 16, err=0, result=0x00000002.
REQ-032 Slave accepts W 3 cycles before AW on every write -> same write order and data, no duplicate AW/W.
REQ-033 BRESP=SLVERR on write to 0x4 -> no further AW, done with err=1, busy low next cycle.
REQ-034 Status never sets done, MAX_POLLS=4, POLL_GAP=8 -> exactly 4 AR handshakes 9+ cycles apart, err=3.
REQ-035 ARESETN low while WVALID high mid-sequence -> all VALIDs 0 immediately; new start after release completes normally.
REQ-036 start pulsed while busy -> ignored; cfg values for running sequence unchanged.
